// File: rtl/rca_byte_serial_adder_pkg.sv
// Shared constants and state encoding for the byte-serial adder.
// Pure declarations, no logic and no latency.
// Not applicable: carries no handshake of its own.
package rca_byte_serial_adder_pkg;

    // Width of one datapath slice handled per clock.
    localparam int BYTE_W = 8;

    // Controller states; the unused code 2'd3 is folded back to IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rca_8bit.sv
// 8-bit ripple-carry adder: sum = a + b + cin, cout = bit 8.
// Purely combinational, zero cycles.
// No handshake; the caller owns all sequencing.
module rca_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] carry;

    // Ripple the carry through eight full-adder bit cells.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < 8; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[8];
    end

endmodule

// File: rtl/rca_byte_serial_adder.sv
// Adds two W-bit operands one byte per clock, LSB first, through a single rca_8bit.
// Accept at edge T0, out_valid from edge T0+NBYTES; next accept no sooner than NBYTES+2 cycles later.
// in_ready only in IDLE; result held in DONE until out_ready, so no operand is taken while a result is pending.
module rca_byte_serial_adder
    import rca_byte_serial_adder_pkg::*;
#(
    parameter  int NBYTES = 4,
    localparam int W      = BYTE_W * NBYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy
);

    localparam int IDX_W = $clog2(NBYTES);
    typedef logic [IDX_W-1:0] idx_t;
    localparam idx_t LAST_IDX = idx_t'(NBYTES - 1);

    state_t         state_q, state_d;
    idx_t           idx_q, idx_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;

    logic [BYTE_W-1:0] lane_a;
    logic [BYTE_W-1:0] lane_b;
    logic [BYTE_W-1:0] lane_sum;
    logic              lane_cout;

    // Select the current byte lane of each latched operand.
    always_comb begin
        lane_a = a_q[BYTE_W * idx_q +: BYTE_W];
        lane_b = b_q[BYTE_W * idx_q +: BYTE_W];
    end

    rca_8bit u_rca_8bit (
        .a    (lane_a),
        .b    (lane_b),
        .cin  (carry_q),
        .sum  (lane_sum),
        .cout (lane_cout)
    );

    // Next-state, byte stepping and result assembly.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[BYTE_W * idx_q +: BYTE_W] = lane_sum;
                carry_d = lane_cout;
                if (idx_q == LAST_IDX) begin
                    // Index stays at the top lane so it never leaves 0..NBYTES-1.
                    cout_d  = lane_cout;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_t'(idx_q + 1'b1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Handshake flags decode from state alone; data comes straight from flops.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_RUN) || (state_q == S_DONE);
        sum       = sum_q;
        cout      = cout_q;
    end

endmodule

// File: tb/tb_rca_byte_serial_adder.sv
// Scoreboard bench for rca_byte_serial_adder with NBYTES=4.
// Inputs driven 1 time unit after the rising edge; outputs sampled at that point.
// Scenario tasks run in sequence and compare inline against queued expectations.
module tb_rca_byte_serial_adder;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;
    localparam int BOUND  = 50;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    logic [W:0]   exp_q[$];
    int           n_checks;
    int           n_fail;

    rca_byte_serial_adder #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits (bounded) for in_ready, presents one operand set, pushes its expected result.
    task automatic accept_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic cv, input logic [W:0] expv, output bit ok);
        int waited;
        waited = 0;
        while (!in_ready && waited < BOUND) begin
            @(posedge clk); #1;
            waited++;
        end
        ok = in_ready;
        if (ok) begin
            in_valid = 1'b1;
            a        = av;
            b        = bv;
            cin      = cv;
            @(posedge clk); #1;
            in_valid = 1'b0;
            exp_q.push_back(expv);
        end
    endtask

    // Waits (bounded) for out_valid; reports how many edges elapsed.
    task automatic wait_out(output bit ok, output int cycles);
        cycles = 0;
        while (!out_valid && cycles < BOUND) begin
            @(posedge clk); #1;
            cycles++;
        end
        ok = out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++; if (sum !== '0) begin n_fail++; $display("FAIL reset_sum got=%h want=0", sum); end
        n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b want=0", cout); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_carry_chain();
        bit         ok;
        logic [W:0] e;
        accept_op(32'h0000001B, 32'h0000004F, 1'b0, {1'b0, 32'h0000006A}, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL chain_accept got=timeout want=accept"); end
        n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL chain_run_flags got busy=%b in_ready=%b want busy=1 in_ready=0", busy, in_ready);
        end
        for (int k = 1; k <= NBYTES; k++) begin
            @(posedge clk); #1;
            n_checks++; if (out_valid !== (k == NBYTES)) begin
                n_fail++; $display("FAIL chain_latency edge=%0d got out_valid=%b want=%b", k, out_valid, (k == NBYTES));
            end
        end
        out_ready = 1'b1;
        e = exp_q.pop_front();
        n_checks++; if ({cout, sum} !== e) begin n_fail++; $display("FAIL chain_result got=%h want=%h", {cout, sum}, e); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL chain_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_vectors();
        logic [W-1:0] ta[3];
        logic [W-1:0] tb[3];
        logic         tc[3];
        logic [W:0]   te[3];
        bit           ok;
        int           cyc;
        logic [W:0]   e;
        ta[0] = 32'hFFFFFFFF; tb[0] = 32'h00000001; tc[0] = 1'b0; te[0] = {1'b1, 32'h00000000};
        ta[1] = 32'hA3A3A3A3; tb[1] = 32'hE0E0E0E0; tc[1] = 1'b0; te[1] = {1'b1, 32'h84848483};
        ta[2] = 32'h00000027; tb[2] = 32'h0000006C; tc[2] = 1'b1; te[2] = {1'b0, 32'h00000094};
        for (int i = 0; i < 3; i++) begin
            accept_op(ta[i], tb[i], tc[i], te[i], ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL vec%0d_accept got=timeout want=accept", i); end
            wait_out(ok, cyc);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL vec%0d_out got=timeout want=out_valid", i); end
            out_ready = 1'b1;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_checks++; if ({cout, sum} !== e) begin n_fail++; $display("FAIL vec%0d_result got=%h want=%h", i, {cout, sum}, e); end
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        bit         ok;
        int         cyc;
        logic [W:0] e;
        accept_op(32'h13572468, 32'h2468ACE0, 1'b1, {1'b0, 32'h37BFD149}, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_accept got=timeout want=accept"); end
        // Operand changes and in_valid while running must be ignored.
        in_valid = 1'b1;
        a        = 32'hDEADBEEF;
        b        = 32'hCAFEF00D;
        cin      = 1'b1;
        wait_out(ok, cyc);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_out got=timeout want=out_valid"); end
        e = (exp_q.size() > 0) ? exp_q[0] : 'x;
        for (int k = 0; k < 5; k++) begin
            in_valid = ~in_valid;
            a        = $urandom;
            b        = $urandom;
            @(posedge clk); #1;
            n_checks++; if ({cout, sum} !== e || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold cyc=%0d got res=%h in_ready=%b out_valid=%b want res=%h in_ready=0 out_valid=1",
                         k, {cout, sum}, in_ready, out_valid, e);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_checks++; if ({cout, sum} !== e) begin n_fail++; $display("FAIL bp_result got=%h want=%h", {cout, sum}, e); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        repeat (NBYTES + 2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_no_extra got busy=%b out_valid=%b want 0/0", busy, out_valid);
        end
        n_checks++; if ({cout, sum} !== e) begin n_fail++; $display("FAIL bp_idle_hold got=%h want=%h", {cout, sum}, e); end
    endtask

    task automatic test_reset_mid();
        bit         ok;
        int         cyc;
        logic [W:0] e;
        accept_op(32'h11111111, 32'h22222222, 1'b0, {1'b0, 32'h33333333}, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_accept got=timeout want=accept"); end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_flags got in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
        end
        n_checks++; if (sum !== '0 || cout !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_data got sum=%h cout=%b want 0/0", sum, cout);
        end
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        accept_op(32'h12345678, 32'h0FEDCBA9, 1'b0, {1'b0, 32'h22222221}, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_follow_accept got=timeout want=accept"); end
        wait_out(ok, cyc);
        n_checks++; if (!ok || cyc != NBYTES) begin
            n_fail++; $display("FAIL rstmid_follow_latency got ok=%0d cycles=%0d want 1/%0d", ok, cyc, NBYTES);
        end
        out_ready = 1'b1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_checks++; if ({cout, sum} !== e) begin n_fail++; $display("FAIL rstmid_follow_result got=%h want=%h", {cout, sum}, e); end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit           ok;
        int           cyc;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic         cv;
        logic [W:0]   e;
        // out_ready held high throughout, including outside DONE.
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            av = $urandom;
            bv = $urandom;
            cv = 1'($urandom_range(0, 1));
            if (i == 0) begin av = '1; bv = '1; cv = 1'b1; end
            accept_op(av, bv, cv, {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv}, ok);
            n_checks++; if (!ok || cyc < 0) begin n_fail++; $display("FAIL b2b%0d_accept got=timeout want=accept", i); end
            wait_out(ok, cyc);
            n_checks++; if (!ok || cyc != NBYTES) begin
                n_fail++; $display("FAIL b2b%0d_latency got ok=%0d cycles=%0d want 1/%0d", i, ok, cyc, NBYTES);
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_checks++; if ({cout, sum} !== e) begin n_fail++; $display("FAIL b2b%0d_result got=%h want=%h", i, {cout, sum}, e); end
            @(posedge clk); #1;
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_release got in_ready=%b want=1", i, in_ready); end
        end
        out_ready = 1'b0;
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_carry_chain();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=still_running want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
